// File: rtl/psg_write_decoder.sv
// psg_write_decoder: SN76489 host write port. Decodes latch/data bytes into the
// tone/attenuation/noise register file and runs the READY wait-state handshake.
// Build option PSG_WE_SYNC_EN: when defined, we_n passes through a 2-flop
// synchroniser before edge detection; otherwise we_n is sampled by the edge flop only.
module psg_write_decoder #(
    parameter int unsigned COUNTER_BITS = 10,
    parameter int unsigned WAIT_CYCLES  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              data,
    input  logic                    we_n,
    output logic                    ready,
    output logic [COUNTER_BITS-1:0] tone0_freq,
    output logic [COUNTER_BITS-1:0] tone1_freq,
    output logic [COUNTER_BITS-1:0] tone2_freq,
    output logic [3:0]              attn0,
    output logic [3:0]              attn1,
    output logic [3:0]              attn2,
    output logic [3:0]              attn3,
    output logic [2:0]              noise_control,
    output logic                    noise_reset
);

    localparam int unsigned HI_W  = COUNTER_BITS - 4;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic [2:0]              latch_q, latch_d;
    logic [COUNTER_BITS-1:0] tone_q [3];
    logic [COUNTER_BITS-1:0] tone_d [3];
    logic [3:0]              attn_q [4];
    logic [3:0]              attn_d [4];
    logic [2:0]              nc_q, nc_d;
    logic                    nr_q, nr_d;
    logic                    fall_c;

`ifdef PSG_WE_SYNC_EN
    logic sync1_q, sync2_q, edge_q;

    // Synchronise the asynchronous strobe, then keep one delayed copy for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            edge_q  <= 1'b1;
        end else begin
            sync1_q <= we_n;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign fall_c = edge_q & ~sync2_q;
`else
    logic edge_q;

    // Host is clock-synchronous: previous strobe sample only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= 1'b1;
        end else begin
            edge_q <= we_n;
        end
    end

    assign fall_c = edge_q & ~we_n;
`endif

    // Handshake FSM and register-file decode of an accepted byte
    always_comb begin
        logic       commit;
        logic [1:0] ch;
        logic       ty;

        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        latch_d = latch_q;
        tone_d  = tone_q;
        attn_d  = attn_q;
        nc_d    = nc_q;
        nr_d    = 1'b0;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall_c) begin
                    commit  = 1'b1;
                    state_d = ST_BUSY;
                    ready_d = 1'b0;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase

        // Latch bytes carry their own target; data bytes reuse the stored latch
        if (data[7]) begin
            ch = data[6:5];
            ty = data[4];
        end else begin
            ch = latch_q[2:1];
            ty = latch_q[0];
        end

        if (commit) begin
            if (data[7]) begin
                latch_d = data[6:4];
            end
            if (ty) begin
                for (int i = 0; i < 4; i++) begin
                    if (ch == 2'(i)) begin
                        attn_d[i] = data[3:0];
                    end
                end
            end else if (ch == 2'd3) begin
                nc_d = data[2:0];
                nr_d = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (ch == 2'(i)) begin
                        if (data[7]) begin
                            tone_d[i] = {tone_q[i][COUNTER_BITS-1:4], data[3:0]};
                        end else begin
                            tone_d[i] = {data[HI_W-1:0], tone_q[i][3:0]};
                        end
                    end
                end
            end
        end
    end

    // State and register file, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            latch_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                tone_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                attn_q[i] <= 4'hF;
            end
            nc_q <= 3'b000;
            nr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            latch_q <= latch_d;
            tone_q  <= tone_d;
            attn_q  <= attn_d;
            nc_q    <= nc_d;
            nr_q    <= nr_d;
        end
    end

    assign ready         = ready_q;
    assign tone0_freq    = tone_q[0];
    assign tone1_freq    = tone_q[1];
    assign tone2_freq    = tone_q[2];
    assign attn0         = attn_q[0];
    assign attn1         = attn_q[1];
    assign attn2         = attn_q[2];
    assign attn3         = attn_q[3];
    assign noise_control = nc_q;
    assign noise_reset   = nr_q;

endmodule

// File: tb/tb_psg_write_decoder.sv
// tb_psg_write_decoder: scoreboard bench for psg_write_decoder. Stimulus pushes
// hand-computed register snapshots; a monitor pops one on every accepted write
// (falling READY) and also times each busy window.
module tb_psg_write_decoder;

    localparam int unsigned CB = 10;
    localparam int unsigned WC = 32;

    typedef struct packed {
        logic [9:0] t0;
        logic [9:0] t1;
        logic [9:0] t2;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [3:0] a2;
        logic [3:0] a3;
        logic [2:0] nc;
        logic       rdy;
        logic       nr;
    } snap_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          we_n = 1'b1;
    logic          ready;
    logic [CB-1:0] tone0_freq, tone1_freq, tone2_freq;
    logic [3:0]    attn0, attn1, attn2, attn3;
    logic [2:0]    noise_control;
    logic          noise_reset;

    snap_t wq[$];
    snap_t dq[$];
    snap_t exp_s;
    int    n_cmp = 0;
    int    n_err = 0;

    psg_write_decoder #(.COUNTER_BITS(CB), .WAIT_CYCLES(WC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data          (data),
        .we_n          (we_n),
        .ready         (ready),
        .tone0_freq    (tone0_freq),
        .tone1_freq    (tone1_freq),
        .tone2_freq    (tone2_freq),
        .attn0         (attn0),
        .attn1         (attn1),
        .attn2         (attn2),
        .attn3         (attn3),
        .noise_control (noise_control),
        .noise_reset   (noise_reset)
    );

    always #5 clk = ~clk;

    function automatic snap_t sample();
        snap_t s;
        s.t0  = tone0_freq;
        s.t1  = tone1_freq;
        s.t2  = tone2_freq;
        s.a0  = attn0;
        s.a1  = attn1;
        s.a2  = attn2;
        s.a3  = attn3;
        s.nc  = noise_control;
        s.rdy = ready;
        s.nr  = noise_reset;
        return s;
    endfunction

    // Monitor: all comparisons happen here, on the falling clock edge
    logic prev_rdy = 1'b1;
    logic busy     = 1'b0;
    int   low_cnt  = 0;
    always @(negedge clk) begin
        snap_t a, e;
        a = sample();
        if (dq.size() > 0) begin
            e = dq.pop_front();
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL direct: got t=%h/%h/%h a=%h%h%h%h nc=%b rdy=%b nr=%b want t=%h/%h/%h a=%h%h%h%h nc=%b rdy=%b nr=%b",
                         a.t0, a.t1, a.t2, a.a0, a.a1, a.a2, a.a3, a.nc, a.rdy, a.nr,
                         e.t0, e.t1, e.t2, e.a0, e.a1, e.a2, e.a3, e.nc, e.rdy, e.nr);
            end
        end
        if (!rst_n) begin
            busy = 1'b0;
        end else if (prev_rdy && !ready) begin
            n_cmp++;
            if (wq.size() == 0) begin
                n_err++;
                $display("FAIL accept: write accepted with nothing expected at %0t", $time);
            end else begin
                e = wq.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL write: got t=%h/%h/%h a=%h%h%h%h nc=%b rdy=%b nr=%b want t=%h/%h/%h a=%h%h%h%h nc=%b rdy=%b nr=%b",
                             a.t0, a.t1, a.t2, a.a0, a.a1, a.a2, a.a3, a.nc, a.rdy, a.nr,
                             e.t0, e.t1, e.t2, e.a0, e.a1, e.a2, e.a3, e.nc, e.rdy, e.nr);
                end
            end
            busy    = 1'b1;
            low_cnt = 1;
        end else if (busy && !ready) begin
            low_cnt++;
            if (low_cnt == 2) begin
                n_cmp++;
                if (noise_reset !== 1'b0) begin
                    n_err++;
                    $display("FAIL pulse_width: noise_reset=%b want 0 at %0t", noise_reset, $time);
                end
            end
        end else if (busy && ready) begin
            n_cmp++;
            if (low_cnt != WC) begin
                n_err++;
                $display("FAIL busy_len: ready low %0d cycles want %0d", low_cnt, WC);
            end
            busy = 1'b0;
        end
        prev_rdy = ready;
    end

    task automatic wait_ready();
        for (int i = 0; i < 200 && ready !== 1'b1; i++) @(negedge clk);
        if (ready !== 1'b1) begin
            $display("FAIL ready_timeout: ready=%b want 1 within 200 cycles", ready);
            $fatal(1, "ready never returned");
        end
    endtask

    task automatic pulse(input logic [7:0] b, input int hold);
        @(negedge clk);
        data = b;
        we_n = 1'b0;
        repeat (hold) @(negedge clk);
        we_n = 1'b1;
        @(negedge clk);
    endtask

    // Push the expected post-write snapshot, then perform the write
    task automatic do_write(input logic [7:0] b, input int hold);
        wait_ready();
        wq.push_back(exp_s);
        pulse(b, hold);
    endtask

    function automatic snap_t reset_snap();
        snap_t s;
        s.t0 = 10'h000; s.t1 = 10'h000; s.t2 = 10'h000;
        s.a0 = 4'hF; s.a1 = 4'hF; s.a2 = 4'hF; s.a3 = 4'hF;
        s.nc = 3'b000; s.rdy = 1'b1; s.nr = 1'b0;
        return s;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dq.push_back(reset_snap());
        @(negedge clk);

        exp_s     = reset_snap();
        exp_s.rdy = 1'b0;

        // Tone 0 via latch + data byte
        exp_s.t0 = 10'h00E;  do_write(8'h8E, 4);
        exp_s.t0 = 10'h0FE;  do_write(8'h0F, 4);

        // Noise register: latch then data byte, each pulses noise_reset
        exp_s.nc = 3'b101; exp_s.nr = 1'b1;  do_write(8'hE5, 4);
        exp_s.nc = 3'b011;                   do_write(8'h03, 4);
        exp_s.nr = 1'b0;

        // Channel 2 attenuation via latch + data byte
        exp_s.a2 = 4'h7;  do_write(8'hD7, 4);
        exp_s.a2 = 4'h2;  do_write(8'h02, 4);

        // Write during busy is dropped
        exp_s.t0 = 10'h0F1;  do_write(8'h81, 4);
        repeat (6) @(negedge clk);
        pulse(8'hC5, 4);
        exp_s.t2 = 10'h005;  do_write(8'hC5, 4);

        // Strobe held low across the whole busy window: exactly one write
        exp_s.t2 = 10'h3F5;  do_write(8'h3F, 45);

        // Reset in the middle of a busy window
        exp_s.a0 = 4'h0;  do_write(8'h90, 4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        dq.push_back(reset_snap());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 50 && (wq.size() > 0 || dq.size() > 0); i++) @(negedge clk);
        if (wq.size() > 0 || dq.size() > 0) begin
            $display("FAIL drain: %0d writes / %0d checks never observed", wq.size(), dq.size());
            $fatal(1, "scoreboard not drained");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
